// File: rtl/prbs_xnor_checker.sv
// Self-synchronising PRBS-7 (x^7 + x^6 + 1, XNOR feedback) bit-error checker.
// Define PRBS_CHK_BITCNT_EN to add the 32-bit bit_count output for BER measurement.
module prbs_xnor_checker #(
   parameter int unsigned LOCK_THRESH = 16,
   parameter int unsigned LOSS_THRESH = 4,
   parameter int unsigned ERR_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din,
   input  logic             din_valid,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err_pulse,
`ifdef PRBS_CHK_BITCNT_EN
   output logic [31:0]      bit_count,
`endif
   output logic [ERR_W-1:0] err_count
);

   localparam int unsigned MATCH_W = $clog2(LOCK_THRESH + 1);
   localparam int unsigned MISS_W  = $clog2(LOSS_THRESH + 1);
   localparam logic [6:0]  LOCKUP  = 7'h7F;

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t             state_q, state_d;
   logic [6:0]         sr_q, sr_d;
   logic [2:0]         seed_q, seed_d;
   logic [MATCH_W-1:0] match_q, match_d;
   logic [MISS_W-1:0]  miss_q, miss_d;
   logic               err_hit;

   logic       pred, mism;
   logic [6:0] sr_din, sr_pred;

   assign pred    = ~(sr_q[6] ^ sr_q[5]);
   assign mism    = din ^ pred;
   assign sr_din  = {sr_q[5:0], din};
   assign sr_pred = {sr_q[5:0], pred};

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= SEARCH;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (din_valid) begin
         unique case (state_q)
            SEARCH: if (seed_q == 3'd6 && sr_din != LOCKUP) state_d = VERIFY;
            VERIFY: begin
               if (mism || sr_din == LOCKUP)                     state_d = SEARCH;
               else if (match_q == MATCH_W'(LOCK_THRESH - 1))    state_d = LOCKED;
            end
            LOCKED: if (mism && miss_q == MISS_W'(LOSS_THRESH - 1)) state_d = SEARCH;
            default: state_d = SEARCH;
         endcase
      end
   end

   // Datapath next values; LOCKED free-runs on its own prediction
   always_comb begin
      sr_d    = sr_q;
      seed_d  = seed_q;
      match_d = match_q;
      miss_d  = miss_q;
      err_hit = 1'b0;
      if (din_valid) begin
         unique case (state_q)
            SEARCH: begin
               sr_d    = sr_din;
               seed_d  = (seed_q == 3'd6) ? 3'd0 : seed_q + 3'd1;
               match_d = '0;
            end
            VERIFY: begin
               sr_d    = sr_din;
               seed_d  = 3'd0;
               match_d = mism ? '0 : match_q + MATCH_W'(1);
               miss_d  = '0;
            end
            LOCKED: begin
               sr_d    = sr_pred;
               seed_d  = 3'd0;
               err_hit = mism;
               miss_d  = mism ? miss_q + MISS_W'(1) : '0;
            end
            default: seed_d = 3'd0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q      <= '0;
         seed_q    <= '0;
         match_q   <= '0;
         miss_q    <= '0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         sr_q      <= sr_d;
         seed_q    <= seed_d;
         match_q   <= match_d;
         miss_q    <= miss_d;
         locked    <= (state_d == LOCKED);
         err_pulse <= err_hit;
         if (clr_cnt)                            err_count <= '0;
         else if (err_hit && err_count != '1)    err_count <= err_count + ERR_W'(1);
      end
   end

`ifdef PRBS_CHK_BITCNT_EN
   // Bits checked while locked, the BER denominator
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) bit_count <= '0;
      else if (din_valid && state_q == LOCKED && bit_count != '1)
         bit_count <= bit_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_prbs_xnor_checker.sv
// Directed + randomized bench for prbs_xnor_checker against a behavioural PRBS-7 checker model.
module tb_prbs_xnor_checker;

   localparam int unsigned LOCK_THRESH = 16;
   localparam int unsigned LOSS_THRESH = 4;
   localparam int unsigned ERR_W       = 16;
   localparam int          CNT_MAX     = (1 << ERR_W) - 1;
   localparam int          M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;

   logic             clk, rst, din, din_valid, clr_cnt;
   logic             locked, err_pulse;
   logic [ERR_W-1:0] err_count;
`ifdef PRBS_CHK_BITCNT_EN
   logic [31:0]      bit_count;
`endif

   prbs_xnor_checker #(.LOCK_THRESH(LOCK_THRESH), .LOSS_THRESH(LOSS_THRESH), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
      .locked(locked), .err_pulse(err_pulse),
`ifdef PRBS_CHK_BITCNT_EN
      .bit_count(bit_count),
`endif
      .err_count(err_count));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   int m_mode, m_sr, m_seed, m_match, m_miss, m_cnt, m_pulse;
   longint m_bits;
   logic [6:0] g;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".locked"}, longint'(locked), longint'(m_mode == M_LOCKED));
      chk({tag, ".err_pulse"}, longint'(err_pulse), longint'(m_pulse));
      chk({tag, ".err_count"}, longint'(err_count), longint'(m_cnt));
`ifdef PRBS_CHK_BITCNT_EN
      chk({tag, ".bit_count"}, longint'(bit_count), m_bits);
`endif
   endtask

   task automatic model_reset();
      m_mode = M_SEARCH; m_sr = 0; m_seed = 0; m_match = 0; m_miss = 0;
      m_cnt = 0; m_pulse = 0; m_bits = 0;
   endtask

   task automatic model_step(input bit v, input bit d, input bit c);
      int pred;
      pred    = 1 - (((m_sr >> 6) & 1) ^ ((m_sr >> 5) & 1));
      m_pulse = 0;
      if (v) begin
         if (m_mode == M_LOCKED && m_bits < 64'hFFFF_FFFF) m_bits++;
         case (m_mode)
            M_SEARCH: begin
               m_sr = (m_sr * 2 + int'(d)) % 128;
               m_seed++;
               if (m_seed == 7) begin
                  m_seed = 0;
                  if (m_sr != 127) begin m_mode = M_VERIFY; m_match = 0; end
               end
            end
            M_VERIFY: begin
               m_sr = (m_sr * 2 + int'(d)) % 128;
               if (int'(d) != pred || m_sr == 127) begin
                  m_mode = M_SEARCH; m_seed = 0;
               end else begin
                  m_match++;
                  if (m_match == LOCK_THRESH) begin m_mode = M_LOCKED; m_miss = 0; end
               end
            end
            default: begin
               m_sr = (m_sr * 2 + pred) % 128;
               if (int'(d) != pred) begin
                  m_pulse = 1;
                  if (m_cnt < CNT_MAX) m_cnt++;
                  m_miss++;
                  if (m_miss == LOSS_THRESH) begin m_mode = M_SEARCH; m_seed = 0; end
               end else m_miss = 0;
            end
         endcase
      end
      if (c) begin m_cnt = 0; m_bits = 0; end
   endtask

   // Reference XNOR PRBS-7 generator
   task automatic gen_bit(output bit b);
      b = ~(g[6] ^ g[5]);
      g = {g[5:0], b};
   endtask

   task automatic tick(input bit v, input bit d, input bit c, input string tag);
      din = d; din_valid = v; clr_cnt = c;
      @(posedge clk);
      model_step(v, d, c);
      #1;
      check_outputs(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1; din_valid = 1'b0; clr_cnt = 1'b0; din = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      check_outputs("reset");
      chk("reset.err_count_zero", longint'(err_count), 0);
      rst = 1'b0;
   endtask

   initial begin
      bit b;
      int lock_at, pulses, vbits;
      bit ever;
      rst = 1'b1; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
      model_reset();
      do_reset();

      // Clean stream from seed 0: lock after exactly 23 valid bits
      g = 7'h00; lock_at = 0;
      for (int i = 1; i <= 1000; i++) begin
         gen_bit(b); tick(1'b1, b, 1'b0, "clean");
         if (locked && lock_at == 0) lock_at = i;
      end
      chk("clean.lock_at", lock_at, 23);
      chk("clean.err_count", longint'(err_count), 0);

      // Single flipped bit while locked
      pulses = 0;
      for (int i = 1; i <= 200; i++) begin
         gen_bit(b); tick(1'b1, (i == 100) ? ~b : b, 1'b0, "flip");
         pulses += int'(err_pulse);
      end
      chk("flip.pulses", pulses, 1);
      chk("flip.err_count", longint'(err_count), 1);
      chk("flip.locked", longint'(locked), 1);

      // Four consecutive errors force loss; relock after 23 clean bits
      gen_bit(b); tick(1'b1, b, 1'b1, "clr");
      for (int i = 0; i < 4; i++) begin gen_bit(b); tick(1'b1, ~b, 1'b0, "loss"); end
      chk("loss.err_count", longint'(err_count), 4);
      chk("loss.locked", longint'(locked), 0);
      lock_at = 0;
      for (int i = 1; i <= 40; i++) begin
         gen_bit(b); tick(1'b1, b, 1'b0, "relock");
         if (locked && lock_at == 0) lock_at = i;
      end
      chk("relock.lock_at", lock_at, 23);

      // Reset while locked with err_count = 5
      gen_bit(b); tick(1'b1, b, 1'b1, "clr2");
      for (int k = 0; k < 60; k++) begin
         gen_bit(b); tick(1'b1, (k % 12 == 5) ? ~b : b, 1'b0, "five");
      end
      chk("five.err_count", longint'(err_count), 5);
      chk("five.locked", longint'(locked), 1);
      do_reset();
      lock_at = 0;
      for (int i = 1; i <= 40; i++) begin
         gen_bit(b); tick(1'b1, b, 1'b0, "rst_relock");
         if (locked && lock_at == 0) lock_at = i;
      end
      chk("rst_relock.lock_at", lock_at, 23);

      // Gappy valid; error coincident with clr_cnt
      do_reset();
      g = 7'h00; lock_at = 0; vbits = 0;
      for (int i = 0; i < 80; i++) begin
         if (i % 2 == 0) begin
            gen_bit(b); tick(1'b1, b, 1'b0, "gappy"); vbits++;
            if (locked && lock_at == 0) lock_at = vbits;
         end else tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, "gappy_idle");
      end
      chk("gappy.lock_at", lock_at, 23);
      gen_bit(b); tick(1'b1, ~b, 1'b0, "gappy_err");
      tick(1'b0, 1'b0, 1'b0, "gappy_idle");
      chk("gappy.idle_pulse", longint'(err_pulse), 0);
      chk("gappy.count_before", longint'(err_count), 1);
      gen_bit(b); tick(1'b1, ~b, 1'b1, "collide");
      chk("collide.err_pulse", longint'(err_pulse), 1);
      chk("collide.err_count", longint'(err_count), 0);

      // Stuck-at-1 never locks
      do_reset();
      ever = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick(1'b1, 1'b1, 1'b0, "stuck");
         ever |= locked;
      end
      chk("stuck.ever_locked", longint'(ever), 0);
      chk("stuck.err_count", longint'(err_count), 0);

      // Randomized valid gaps, error bursts and clears against the model
      do_reset();
      g = 7'($urandom_range(0, 126));
      for (int i = 0; i < 4000; i++) begin
         bit v, flip, c;
         v    = ($urandom_range(0, 3) != 0);
         flip = ($urandom_range(0, 59) == 0) || (i % 700 >= 600 && i % 700 < 606);
         c    = ($urandom_range(0, 149) == 0);
         if (v) begin gen_bit(b); tick(1'b1, flip ? ~b : b, c, "rand"); end
         else tick(1'b0, 1'($urandom_range(0, 1)), 1'b0, "rand_idle");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prbs_xnor_checker.md
# prbs_xnor_checker

Serial PRBS-7 receiver/checker for the XNOR-feedback LFSR generator (polynomial x^7 + x^6 + 1). It sits at the receive end of a bit-serial test link. It self-synchronises to the incoming stream, declares lock, and then counts bit errors against a free-running local prediction. It drops lock on sustained mismatch and re-acquires automatically.

## Interface
Parameters:
- LOCK_THRESH, default 16: consecutive matching bits in VERIFY required to declare lock.
- LOSS_THRESH, default 4: consecutive mismatches in LOCKED that force loss of lock.
- ERR_W, default 16: width of the error counter.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  1  received serial bit.
- din_valid  input  1  din is sampled only when this is high.
- clr_cnt  input  1  synchronous clear of err_count.
- locked  output  1  checker is in LOCKED.
- err_pulse  output  1  one-cycle strobe, one per counted error.
- err_count  output  ERR_W  saturating error count.

## Operation
- Shift register sr[6:0]; shift is sr <= {sr[5:0], bit}. Prediction is pred = ~(sr[6] ^ sr[5]).
- All-ones (7'h7F) is the XNOR lock-up state and is never a valid seed.
- Nothing changes on cycles with din_valid low: state, sr and counters hold, and err_pulse is 0.
- The FSM has three states: SEARCH, VERIFY and LOCKED.
- SEARCH:
  - Shift din into sr and increment the 3-bit seed count.
  - After the 7th valid bit, go to VERIFY if the new sr is not 7'h7F.
  - If the new sr is 7'h7F, restart seeding (seed count to 0) and stay in SEARCH.
- VERIFY:
  - Compare din with pred, then shift din into sr.
  - On a match, increment the match count. On the LOCK_THRESH-th consecutive match, go to LOCKED.
  - On a mismatch, go to SEARCH with the seed count reset. No error is counted.
  - If sr becomes 7'h7F, go to SEARCH.
- LOCKED:
  - Shift pred, not din, into sr. This is free-running, so one line error counts once.
  - A mismatch asserts err_pulse, increments err_count (saturating at all-ones) and increments the miss count.
  - A match clears the miss count.
  - On the LOSS_THRESH-th consecutive mismatch, go to SEARCH. That mismatch is still counted.
- clr_cnt:
  - Sets err_count to 0 and has priority over a simultaneous increment.
  - err_pulse still fires in that case.
  - clr_cnt does not affect the FSM.
- Reset sets the FSM to SEARCH and sr, the seed count, the match count, the miss count, locked, err_pulse and err_count to 0. This applies at any time, including mid-lock.

## Timing
- All outputs are registered.
- err_pulse is high in the cycle after the rising edge that sampled the erroneous valid bit.
- locked rises in the cycle after the edge that sampled the LOCK_THRESH-th match. It falls in the cycle after the edge that sampled the LOSS_THRESH-th miss.
- Minimum acquisition is 7 + LOCK_THRESH valid bits (23 with defaults), with no gaps required between them.
- Back-to-back valid bits are supported, so throughput is 1 bit per clock.
- Reset output values are locked 0, err_pulse 0 and err_count 0, visible in the cycle after the reset edge.

## Configuration
- Macro: PRBS_CHK_BITCNT_EN.
- Defined:
  - Adds the output port bit_count (32 bits).
  - bit_count counts valid bits checked while LOCKED and saturates at 32'hFFFFFFFF.
  - It is cleared by rst and by clr_cnt. This enables BER = err_count / bit_count.
- Not defined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
- **Clean stream:** after rst, drive din from the XNOR PRBS-7 generator seeded 7'h00, with din_valid=1 continuously. locked rises after exactly 23 valid bits. err_count stays 0 over 1000 bits.
- **Single flip:** once locked, invert bit 100 only. Expect exactly one err_pulse, err_count=1, and locked held high.
- **Loss and relock:** once locked, invert 4 consecutive bits. Expect err_count=4 and locked low in the cycle after the 4th. locked rises again after 23 further clean bits.
- **Stuck-at-1:** hold din=1 with din_valid=1 for 200 cycles. locked never asserts and err_count stays 0.
- **Gappy valid with clr/error collision:** use a generator stream with din_valid toggling 1/0, and expect lock after 23 valid bits. Assert clr_cnt on the same valid cycle as an injected error. Expect err_pulse=1 and err_count=0 afterwards.
- **Reset mid-lock:** assert rst while locked with err_count=5. Next cycle: locked=0, err_pulse=0, err_count=0. Relock takes 23 bits.
